// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive buffer between the byte-level UART receiver and the register file.
// Each completed receive byte is captured into a DEPTH-entry circular FIFO.
// The oldest byte is presented on a show-ahead read port. The block also
// reports occupancy, a watermark interrupt and sticky error flags.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   rx_valid_i   receiver "byte available" level (one push per high level)
//   rx_data_i    received byte, stable while rx_valid_i is high
//   rx_break_i   receiver break-detected level
//   rd_en_i      pop pulse from the data-register read
//   flush_i      synchronous FIFO empty pulse
//   clear_err_i  clears overflow_o / break_seen_o
//   threshold_i  watermark level, 0 disables irq_o
//   rd_data_o    oldest byte, 0 when empty
//   count_o      occupancy 0..DEPTH
//   empty_o      count == 0
//   full_o       count == DEPTH
//   overflow_o   sticky: a byte was dropped
//   break_seen_o sticky: a break condition started
//   irq_o        count >= threshold and threshold != 0
//   status_o     {3'b0, break_seen, overflow, irq, full, empty}
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          rx_valid_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_break_i,
    input  logic          rd_en_i,
    input  logic          flush_i,
    input  logic          clear_err_i,
    input  logic [CW-1:0] threshold_i,
    output logic [7:0]    rd_data_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          overflow_o,
    output logic          break_seen_o,
    output logic          irq_o,
    output logic [7:0]    status_o
);

    localparam int AW = $clog2(DEPTH);

    // Storage and state
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rx_valid_q;
    logic          rx_break_q;
    logic          ovf_q, ovf_d;
    logic          brk_q, brk_d;

    // Event decode
    logic push_req;
    logic break_rise;
    logic push;
    logic pop;
    logic wr_en;
    logic is_empty;
    logic is_full;

    assign is_empty   = (cnt_q == '0);
    assign is_full    = (cnt_q == CW'(DEPTH));

    // One push per rising level of rx_valid; an edge that arrives while the
    // receiver reports a break is consumed without storing anything.
    assign push_req   = rx_valid_i & ~rx_valid_q & ~rx_break_i;
    assign break_rise = rx_break_i & ~rx_break_q;

    assign push       = push_req & ~flush_i;
    assign pop        = rd_en_i & ~is_empty & ~flush_i;

    // When full, a simultaneous pop frees the head slot this same edge, so
    // the incoming byte may overwrite mem[wp] (== mem[rp]) safely.
    assign wr_en      = push & (~is_full | pop);

    // Next-state logic for pointers, count and sticky flags
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q & ~clear_err_i;
        brk_d = brk_q & ~clear_err_i;

        if (flush_i) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (wr_en) begin
                wp_d = wp_q + AW'(1);
            end
            if (pop) begin
                rp_d = rp_q + AW'(1);
            end
            unique case ({wr_en, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        // Set events take priority over clear_err in the same cycle.
        if (push & is_full & ~pop) begin
            ovf_d = 1'b1;
        end
        if (break_rise) begin
            brk_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            rx_valid_q <= 1'b0;
            rx_break_q <= 1'b0;
            ovf_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            rx_valid_q <= rx_valid_i;
            rx_break_q <= rx_break_i;
            ovf_q      <= ovf_d;
            brk_q      <= brk_d;
        end
    end

    // Array contents need no reset; only entries below count are ever read.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wp_q] <= rx_data_i;
        end
    end

    // Combinational outputs
    assign rd_data_o    = is_empty ? 8'h00 : mem_q[rp_q];
    assign count_o      = cnt_q;
    assign empty_o      = is_empty;
    assign full_o       = is_full;
    assign overflow_o   = ovf_q;
    assign break_seen_o = brk_q;
    assign irq_o        = (threshold_i != '0) && (cnt_q >= threshold_i);
    assign status_o     = {3'b000, brk_q, ovf_q, irq_o, is_full, is_empty};

endmodule
